// File: rtl/array_pkg.sv
// Shared types and defaults for the array allocator.
//   MemoryElementWidth : default width of array numbers, sizes and counts
//   NArrays            : default maximum number of arrays
//   req_op_e           : request opcode carried on req_free
//   idx_width()        : storage index width for a table of a given depth
package array_pkg;

  localparam int unsigned MemoryElementWidth = 12;
  localparam int unsigned NArrays            = 2000;

  typedef enum logic {
    REQ_ALLOC = 1'b0,
    REQ_FREE  = 1'b1
  } req_op_e;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/free_stack.sv
// LIFO of freed array numbers.
//   clock, reset_n : clock, async active-low reset (count cleared, contents kept)
//   push/push_data : push a number (ignored when full)
//   pop            : drop the top entry (ignored when empty)
//   top            : current top entry (0 when empty)
//   count          : current depth; full/empty flags
module free_stack #(
  parameter int unsigned Width = array_pkg::MemoryElementWidth,
  parameter int unsigned Depth = array_pkg::NArrays
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] top,
  output logic [Width-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IdxW = array_pkg::idx_width(Depth);
  localparam logic [Width-1:0] DepthW = Width'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count >= DepthW);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign count     = r_count;
  assign top       = empty ? '0 : r_mem[IdxW'(r_count - Width'(1))];

  // Storage is not reset; only the depth counter defines what is valid.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[IdxW'(r_count)] <= push_data;
    end
  end

  // Depth counter, saturating at both ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_do_push) begin
      r_count <= r_count + Width'(1);
    end else if (w_do_pop) begin
      r_count <= r_count - Width'(1);
    end
  end

endmodule

// File: rtl/array_allocator.sv
// Array-number allocator with LIFO reuse of freed numbers and a per-array
// size table.
//   clock, reset_n                     : clock, async active-low reset
//   req_valid/req_ready/req_free/req_array : request (alloc or free)
//   rsp_valid/rsp_array/rsp_error      : one-cycle response, one cycle after accept
//   size_we/size_array/size_value      : size table write port
//   size_rd_array/size_rd              : size table read port, 1-cycle latency
//   allocs                             : high-water mark of issued numbers
//   free_count                         : current free-stack depth
// Optional: define ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN to track an in-use
// bit per array and reject frees of arrays that are not allocated.
module array_allocator #(
  parameter int unsigned MemoryElementWidth = array_pkg::MemoryElementWidth,
  parameter int unsigned NArrays            = array_pkg::NArrays
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_free,
  input  logic [MemoryElementWidth-1:0] req_array,
  output logic                          rsp_valid,
  output logic [MemoryElementWidth-1:0] rsp_array,
  output logic                          rsp_error,
  input  logic                          size_we,
  input  logic [MemoryElementWidth-1:0] size_array,
  input  logic [MemoryElementWidth-1:0] size_value,
  input  logic [MemoryElementWidth-1:0] size_rd_array,
  output logic [MemoryElementWidth-1:0] size_rd,
  output logic [MemoryElementWidth-1:0] allocs,
  output logic [MemoryElementWidth-1:0] free_count
);

  localparam int unsigned W    = MemoryElementWidth;
  localparam int unsigned IdxW = array_pkg::idx_width(NArrays);
  localparam logic [W-1:0] LimitW = W'(NArrays);

  array_pkg::req_op_e w_op;
  logic               w_accept;
  logic               w_stack_empty;
  logic               w_stack_full;
  logic [W-1:0]       w_stack_top;
  logic [W-1:0]       w_free_count;
  logic               w_pop;
  logic               w_push;
  logic               w_issue_new;
  logic               w_err;
  logic               w_clear;
  logic               w_free_ok;
  logic               w_size_wr;
  logic [W-1:0]       w_rsp_array;
  logic [W-1:0]       w_size_rd_next;

  logic               r_rsp_valid;
  logic               r_rsp_error;
  logic [W-1:0]       r_rsp_array;
  logic [W-1:0]       r_allocs;
  logic [W-1:0]       r_size_rd;
  logic [W-1:0]       r_size [NArrays];

  // Ready is simply "out of reset"; a request can be taken every cycle.
  assign req_ready = reset_n;
  assign w_accept  = req_valid && req_ready;
  assign w_op      = array_pkg::req_op_e'(req_free);

`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  logic [NArrays-1:0] r_in_use;

  assign w_free_ok = r_in_use[IdxW'(req_array)];

  // In-use bit per array: set on a successful allocate, cleared on a free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_in_use <= '0;
    end else if (w_pop || w_issue_new) begin
      r_in_use[IdxW'(w_rsp_array)] <= 1'b1;
    end else if (w_push) begin
      r_in_use[IdxW'(req_array)] <= 1'b0;
    end
  end
`else
  assign w_free_ok = 1'b1;
`endif

  free_stack #(
    .Width (W),
    .Depth (NArrays)
  ) u_free_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (req_array),
    .pop       (w_pop),
    .top       (w_stack_top),
    .count     (w_free_count),
    .full      (w_stack_full),
    .empty     (w_stack_empty)
  );

  // Request decode: pick the response and the state updates for this edge.
  // A free into a full stack is rejected so free_count saturates.
  always_comb begin
    w_pop       = 1'b0;
    w_push      = 1'b0;
    w_issue_new = 1'b0;
    w_err       = 1'b0;
    w_clear     = 1'b0;
    w_rsp_array = '0;
    if (w_accept) begin
      if (w_op == array_pkg::REQ_ALLOC) begin
        if (!w_stack_empty) begin
          w_pop       = 1'b1;
          w_clear     = 1'b1;
          w_rsp_array = w_stack_top;
        end else if (r_allocs < LimitW) begin
          w_issue_new = 1'b1;
          w_clear     = 1'b1;
          w_rsp_array = r_allocs;
        end else begin
          w_err = 1'b1;
        end
      end else begin
        w_rsp_array = req_array;
        if ((req_array >= r_allocs) || w_stack_full || !w_free_ok) begin
          w_err = 1'b1;
        end else begin
          w_push  = 1'b1;
          w_clear = 1'b1;
        end
      end
    end
  end

  // Size write is dropped when the allocator clears the same array this edge.
  assign w_size_wr = size_we && (size_array < LimitW) &&
                     !(w_clear && (size_array == w_rsp_array));

  // Read returns the post-edge value of the addressed entry.
  always_comb begin
    w_size_rd_next = '0;
    if (size_rd_array >= LimitW) begin
      w_size_rd_next = '0;
    end else if (w_clear && (w_rsp_array == size_rd_array)) begin
      w_size_rd_next = '0;
    end else if (w_size_wr && (size_array == size_rd_array)) begin
      w_size_rd_next = size_value;
    end else begin
      w_size_rd_next = r_size[IdxW'(size_rd_array)];
    end
  end

  // Size table storage (not reset).
  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_size[IdxW'(w_rsp_array)] <= '0;
    end
    if (w_size_wr) begin
      r_size[IdxW'(size_array)] <= size_value;
    end
  end

  // Response, high-water mark and size read registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
      r_rsp_array <= '0;
      r_allocs    <= '0;
      r_size_rd   <= '0;
    end else begin
      r_rsp_valid <= w_accept;
      r_rsp_error <= w_err;
      r_rsp_array <= w_rsp_array;
      r_size_rd   <= w_size_rd_next;
      if (w_issue_new) begin
        r_allocs <= r_allocs + W'(1);
      end
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_error  = r_rsp_error;
  assign rsp_array  = r_rsp_array;
  assign allocs     = r_allocs;
  assign size_rd    = r_size_rd;
  assign free_count = w_free_count;

endmodule

// File: tb/tb_array_allocator.sv
// Self-checking bench for array_allocator (NArrays = 4): directed scenarios
// followed by random traffic checked against a queue-based reference model.
module tb_array_allocator;

  localparam int unsigned W  = 12;
  localparam int          NA = 4;
`ifdef ARRAY_ALLOCATOR_DOUBLE_FREE_CHECK_EN
  localparam bit DFC = 1'b1;
`else
  localparam bit DFC = 1'b0;
`endif

  logic         clock;
  logic         reset_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_free;
  logic [W-1:0] req_array;
  logic         rsp_valid;
  logic [W-1:0] rsp_array;
  logic         rsp_error;
  logic         size_we;
  logic [W-1:0] size_array;
  logic [W-1:0] size_value;
  logic [W-1:0] size_rd_array;
  logic [W-1:0] size_rd;
  logic [W-1:0] allocs;
  logic [W-1:0] free_count;

  array_allocator #(
    .MemoryElementWidth (W),
    .NArrays            (NA)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_free      (req_free),
    .req_array     (req_array),
    .rsp_valid     (rsp_valid),
    .rsp_array     (rsp_array),
    .rsp_error     (rsp_error),
    .size_we       (size_we),
    .size_array    (size_array),
    .size_value    (size_value),
    .size_rd_array (size_rd_array),
    .size_rd       (size_rd),
    .allocs        (allocs),
    .free_count    (free_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: free list as a queue, counters as plain ints.
  int stk[$];
  int m_allocs;
  bit m_in_use [NA];
  int m_size   [NA];
  bit m_known  [NA];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    stk.delete();
    m_allocs = 0;
    for (int i = 0; i < NA; i++) m_in_use[i] = 1'b0;
  endtask

  // One clock of stimulus; checks the response and status one edge later.
  task automatic step(input bit v, input bit fr, input int arr, input bit we,
                      input int wa, input int wv, input int ra, input string tag);
    bit e_err = 1'b0;
    int e_arr = 0;
    int clr   = -1;
    int e_rd  = 0;
    bit rd_ok = 1'b1;
    if (v) begin
      if (!fr) begin
        if (stk.size() > 0) begin
          e_arr = stk.pop_back();
          clr   = e_arr;
        end else if (m_allocs < NA) begin
          e_arr = m_allocs;
          m_allocs++;
          clr   = e_arr;
        end else begin
          e_err = 1'b1;
        end
        if (clr >= 0) m_in_use[clr] = 1'b1;
      end else begin
        e_arr = arr;
        if (arr >= m_allocs || stk.size() >= NA || (DFC && !m_in_use[arr])) begin
          e_err = 1'b1;
        end else begin
          stk.push_back(arr);
          m_in_use[arr] = 1'b0;
          clr = arr;
        end
      end
    end
    if (clr >= 0) begin
      m_size[clr]  = 0;
      m_known[clr] = 1'b1;
    end
    if (we && wa < NA && wa != clr) begin
      m_size[wa]  = wv;
      m_known[wa] = 1'b1;
    end
    if (ra < NA) begin
      e_rd  = m_size[ra];
      rd_ok = m_known[ra];
    end

    req_valid     = v;
    req_free      = fr;
    req_array     = W'(arr);
    size_we       = we;
    size_array    = W'(wa);
    size_value    = W'(wv);
    size_rd_array = W'(ra);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    size_we   = 1'b0;

    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(v));
    if (v) begin
      chk({tag, "_rsp_error"}, 32'(rsp_error), 32'(e_err));
      if (!(fr && e_err)) chk({tag, "_rsp_array"}, 32'(rsp_array), 32'(e_arr));
    end
    chk({tag, "_allocs"}, 32'(allocs), 32'(m_allocs));
    chk({tag, "_free_count"}, 32'(free_count), 32'(stk.size()));
    if (rd_ok) chk({tag, "_size_rd"}, 32'(size_rd), 32'(e_rd));
  endtask

  task automatic alloc(input string tag);
    step(1'b1, 1'b0, 0, 1'b0, 0, 0, NA, tag);
  endtask

  task automatic free_arr(input int a, input string tag);
    step(1'b1, 1'b1, a, 1'b0, 0, 0, NA, tag);
  endtask

  // Reset asserted between edges with a request pending; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clock);
    req_valid = 1'b1;
    req_free  = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_rsp_array"}, 32'(rsp_array), 32'd0);
    chk({tag, "_allocs"}, 32'(allocs), 32'd0);
    chk({tag, "_free_count"}, 32'(free_count), 32'd0);
    chk({tag, "_size_rd"}, 32'(size_rd), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_held_rsp_valid"}, 32'(rsp_valid), 32'd0);
    reset_n   = 1'b1;
    req_valid = 1'b0;
    model_reset();
    #1;
    chk({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    reset_n       = 1'b0;
    req_valid     = 1'b0;
    req_free      = 1'b0;
    req_array     = '0;
    size_we       = 1'b0;
    size_array    = '0;
    size_value    = '0;
    size_rd_array = '0;
    for (int i = 0; i < NA; i++) begin
      m_size[i]  = 0;
      m_known[i] = 1'b0;
    end
    model_reset();

    do_reset("init");

    // Give every size entry a known value; same-edge read sees the write.
    for (int i = 0; i < NA; i++)
      step(1'b0, 1'b0, 0, 1'b1, i, 100 + i, i, $sformatf("szinit%0d", i));

    // alloc/free ping-pong always reuses array 0.
    alloc("p1_a0");
    free_arr(0, "p1_f0");
    alloc("p1_a1");
    free_arr(0, "p1_f1");
    alloc("p1_a2");
    chk("p1_rsp0", 32'(rsp_array), 32'd0);
    chk("p1_allocs1", 32'(allocs), 32'd1);

    // LIFO reuse of a freed middle number.
    do_reset("rst2");
    alloc("p2_a0");
    alloc("p2_a1");
    alloc("p2_a2");
    chk("p2_third", 32'(rsp_array), 32'd2);
    free_arr(1, "p2_f1");
    alloc("p2_a3");
    chk("p2_reuse1", 32'(rsp_array), 32'd1);
    chk("p2_fc0", 32'(free_count), 32'd0);

    // Exhaustion: fifth allocate fails with array 0.
    do_reset("rst3");
    for (int i = 0; i < 5; i++) alloc($sformatf("p3_a%0d", i));
    chk("p3_err", 32'(rsp_error), 32'd1);
    chk("p3_arr0", 32'(rsp_array), 32'd0);
    chk("p3_allocs4", 32'(allocs), 32'd4);

    // Out-of-range free and repeated free.
    do_reset("rst4");
    alloc("p4_a0");
    alloc("p4_a1");
    free_arr(7, "p4_f7");
    chk("p4_f7_err", 32'(rsp_error), 32'd1);
    chk("p4_f7_fc", 32'(free_count), 32'd0);
    free_arr(0, "p4_f0a");
    free_arr(0, "p4_f0b");
    chk("p4_dbl_err", 32'(rsp_error), 32'(DFC));

    // Size cleared by reuse; same-edge write loses to the clear.
    do_reset("rst5");
    alloc("p5_a0");
    step(1'b0, 1'b0, 0, 1'b1, 0, 5, 0, "p5_w5");
    chk("p5_sz5", 32'(size_rd), 32'd5);
    free_arr(0, "p5_f0");
    alloc("p5_a1");
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, "p5_rd");
    chk("p5_sz0", 32'(size_rd), 32'd0);
    step(1'b0, 1'b0, 0, 1'b1, 0, 9, 0, "p5_w9");
    step(1'b1, 1'b1, 0, 1'b1, 0, 7, 0, "p5_race");
    chk("p5_race_sz", 32'(size_rd), 32'd0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 0, 0, "p5_rd2");
    chk("p5_race_sz2", 32'(size_rd), 32'd0);

    // Mid-stream reset right after a response, then fresh allocate.
    alloc("p6_a");
    alloc("p6_b");
    do_reset("p6_rst");
    alloc("p6_after");
    chk("p6_first0", 32'(rsp_array), 32'd0);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      bit v  = ($urandom_range(0, 9) < 8);
      bit fr = $urandom_range(0, 1) == 1;
      bit we = ($urandom_range(0, 9) < 3);
      if (n == 200) do_reset("rnd_rst");
      step(v, fr, int'($urandom_range(0, 7)), we, int'($urandom_range(0, 5)),
           int'($urandom_range(0, 4095)), int'($urandom_range(0, 5)),
           $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
